// File: rtl/unidad_acceso_memoria.sv
// Load/store initiator for the data memory: word/half/byte access, read-modify-write subword stores.
// Optional CONTADORES_EN adds saturating load/store completion counters.
module unidad_acceso_memoria #(
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic              resp_error,
   output logic              mem_escr,
   output logic              mem_leer,
   output logic [ADDR_W-1:0] mem_direc,
   output logic [31:0]       mem_datain,
   input  logic [31:0]       mem_dataout
`ifdef CONTADORES_EN
   ,
   output logic [15:0]       cnt_lecturas,
   output logic [15:0]       cnt_escrituras
`endif
);

   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse in RESP.

   typedef enum logic [2:0] {IDLE, RD, WAIT, CAP, WR, RESP} state_t;

   localparam int            WAIT_INIT_I = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
   localparam logic [1:0]    WAIT_INIT   = 2'(WAIT_INIT_I);

   state_t              state_q, state_d;
   logic [ADDR_W+1:0]   addr_q, addr_d;
   logic [1:0]          size_q, size_d;
   logic                signed_q, signed_d;
   logic                write_q, write_d;
   logic [15:0]         wdata_q, wdata_d;
   logic [31:0]         datain_q, datain_d;
   logic [31:0]         resp_data_q, resp_data_d;
   logic                resp_error_q, resp_error_d;
   logic [1:0]          wait_q, wait_d;

   logic                req_bad;
   logic [7:0]          rd_byte;
   logic [15:0]         rd_half;
   logic [31:0]         load_val;
   logic [31:0]         merged;

   assign req_bad = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   // Little-endian lanes: byte k occupies bits 8k+7:8k.
   always_comb begin
      rd_byte  = mem_dataout[{addr_q[1:0], 3'b000} +: 8];
      rd_half  = mem_dataout[{addr_q[1], 4'b0000} +: 16];
      load_val = mem_dataout;
      merged   = mem_dataout;
      case (size_q)
         2'b00: begin
            load_val = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            load_val = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      size_d       = size_q;
      signed_d     = signed_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      datain_d     = datain_q;
      resp_data_d  = resp_data_q;
      resp_error_d = resp_error_q;
      wait_d       = wait_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               size_d   = req_size;
               signed_d = req_signed;
               write_d  = req_write;
               wdata_d  = req_wdata[15:0];
               if (req_bad) begin
                  resp_data_d  = 32'h0;
                  resp_error_d = 1'b1;
                  state_d      = RESP;
               end else if (req_write && req_size == 2'b10) begin
                  datain_d = req_wdata;
                  state_d  = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            wait_d  = WAIT_INIT;
            state_d = (MEM_LAT > 1) ? WAIT : CAP;
         end
         WAIT: begin
            if (wait_q == 2'd0) state_d = CAP;
            else                wait_d  = wait_q - 2'd1;
         end
         CAP: begin
            if (write_q) begin
               datain_d = merged;
               state_d  = WR;
            end else begin
               resp_data_d  = load_val;
               resp_error_d = 1'b0;
               state_d      = RESP;
            end
         end
         WR: begin
            resp_data_d  = 32'h0;
            resp_error_d = 1'b0;
            state_d      = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         write_q      <= 1'b0;
         wdata_q      <= 16'h0;
         datain_q     <= 32'h0;
         resp_data_q  <= 32'h0;
         resp_error_q <= 1'b0;
         wait_q       <= 2'd0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         datain_q     <= datain_d;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
         wait_q       <= wait_d;
      end
   end

   // Strobes decode straight from the state register so reset drops them immediately.
   assign req_ready  = (state_q == IDLE);
   assign mem_leer   = (state_q == RD);
   assign mem_escr   = (state_q == WR);
   assign resp_valid = (state_q == RESP);
   assign resp_data  = resp_data_q;
   assign resp_error = resp_error_q;
   assign mem_direc  = addr_q[ADDR_W+1:2];
   assign mem_datain = datain_q;

`ifdef CONTADORES_EN
   logic [15:0] cnt_lec_q, cnt_esc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_lec_q <= 16'h0;
         cnt_esc_q <= 16'h0;
      end else if (state_q == RESP && !resp_error_q) begin
         if (write_q && cnt_esc_q != 16'hFFFF)       cnt_esc_q <= cnt_esc_q + 16'd1;
         else if (!write_q && cnt_lec_q != 16'hFFFF) cnt_lec_q <= cnt_lec_q + 16'd1;
      end
   end

   assign cnt_lecturas   = cnt_lec_q;
   assign cnt_escrituras = cnt_esc_q;
`endif

endmodule
